ama_riscv_lsu_ctrl: RTL and testbench
=====================================

# ama_riscv_lsu_ctrl

Load/store unit sequencer between the pipeline memory stage and the 32-bit word-addressed DMEM. Aligned byte, half and word accesses complete in one DMEM access and can be issued back-to-back. Accesses that cross a word boundary are split into two sequential word accesses, with the pipeline stalled for one cycle. For loads, the controller merges the two words, then shifts, masks and extends the result before returning it.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  pipeline memory request
- `req_ready`  out  1  controller can accept a request this cycle
- `req_we`  in  1  1: store, 0: load
- `req_addr`  in  32  byte address
- `req_width`  in  3  funct3 encoding
  - bit2: 1 = unsigned (loads only)
  - [1:0]: 0 = byte, 1 = half, 2 = word
- `req_wdata`  in  32  store data, right-aligned
- `resp_valid`  out  1  load data valid
- `resp_rdata`  out  32  load result; 32'h0 when `resp_valid`=0
- `resp_err`  out  1  invalid width; qualified by `resp_valid`
- `dmem_en`  out  1  DMEM access strobe
- `dmem_we`  out  4  byte write enables
- `dmem_addr`  out  30  word address
- `dmem_wdata`  out  32  lane-aligned write data
- `dmem_rdata`  in  32  read data, valid one cycle after a read access (synchronous read)

## Operation
- Accept condition: `req_valid && req_ready`.
- Offset `off` = `req_addr[1:0]`. Word address `wa` = `req_addr[31:2]`.
- Split condition:
  - half with `off`=3, or
  - word with `off`≠0.
- Invalid width: `req_width[1:0]`=3, or `req_width`=3'b110.
- FSM states:
  - IDLE: `req_ready`=1.
  - SPLIT: `req_ready`=0; second access in progress.
- IDLE, accept, non-split, valid width:
  - Drive `dmem_en`=1 and `dmem_addr`=`wa` combinationally in the same cycle.
  - Store: `dmem_we` = byte mask `((1<<nbytes)-1)<<off`. `dmem_wdata` = `req_wdata<<(8*off)`.
  - Load: register `off`, width and sign into a pending slot; stay in IDLE.
- IDLE, accept, split:
  - First access uses `wa` and covers the low part.
  - Store `dmem_we` = `(mask<<off)[3:0]`. Load: `dmem_we`=0.
  - Register the request; go to SPLIT.
- SPLIT:
  - Issue the second access to `wa+1`. The 30-bit add wraps, so `0x3FFFFFFF+1` = 0.
  - Store `dmem_we` = `(mask<<off)[7:4]`. `dmem_wdata` = `(req_wdata<<(8*off))>>32`, using the registered copy.
  - Load: capture `dmem_rdata` (the low word) into the merge buffer.
  - Always return to IDLE on the next cycle.
- Load result:
  - Form the 64-bit value `{high, low}`. For a non-split access, high = 0 and low = `dmem_rdata`.
  - Select `nbytes` starting at byte `off`.
  - Extend: byte or half is zero-extended if bit2=1, else sign-extended. Word is passed unchanged.
- Invalid width:
  - Accept the request with no DMEM activity.
  - Load: `resp_valid`=1 next cycle with `resp_rdata`=0 and `resp_err`=1.
  - Store: silently dropped.
- Stores generate no response.
- `dmem_en`=0 and `dmem_we`=0 in every cycle without an access.
- Reset:
  - State goes to IDLE; pending slot and merge buffer are cleared.
  - An in-flight load produces no response.
  - While `rst`=1: `req_ready`=0, `dmem_en`=0, `dmem_we`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.

## Timing
- Non-split load accepted at T: `resp_valid` at T+1. `req_ready`=1 at T+1, so a new request can be accepted at T+1 (one per cycle throughput).
- Split load accepted at T:
  - DMEM access 1 at T, access 2 at T+1.
  - `req_ready`=0 at T+1.
  - `resp_valid` at T+2; a new request can be accepted at T+2.
- Split store accepted at T: writes at T and T+1; `req_ready`=0 at T+1.
- Same cycle as a response:
  - A load response at T+1 may coincide with a new access issued at T+1; both proceed.
  - `dmem_rdata` at T+1 belongs to the T access.
- `resp_valid` is a single-cycle pulse. There is no backpressure on the response.
- `rst` asserted in SPLIT: the second access is suppressed in that cycle. No response follows.

## Test plan
- DMEM word0=0x44332211, word1=0x88776655.
  - LB at 0x1 -> `resp_rdata`=0x00000022 at T+1.
  - LBU at 0x7 -> 0x00000088.
  - LB at 0x7 -> 0xFFFFFF88.
- LH at 0x3 (split) -> `req_ready`=0 at T+1; `dmem_addr` is 0 then 1; `resp_rdata`=0x00005544 at T+2. LW at 0x2 -> 0x66554433 at T+2.
- SW 0xAABBCCDD at 0x3:
  - T: `dmem_addr`=0, `dmem_we`=4'b1000, `dmem_wdata[31:24]`=0xDD.
  - T+1: `dmem_addr`=1, `dmem_we`=4'b0111, `dmem_wdata[23:0]`=0xAABBCC.
- Back-to-back aligned LW at 0x0, 0x4, 0x0 on consecutive cycles -> three `resp_valid` pulses on consecutive cycles: 0x44332211, 0x88776655, 0x44332211.
- LW at 0xFFFFFFFE -> second `dmem_addr`=0. Width 3'b011 load -> `resp_err`=1, `resp_rdata`=0, no `dmem_en`.
- `rst` pulsed during the SPLIT cycle of LW at 0x1 -> no `resp_valid`, no second access. `req_ready` is 0 during reset and 1 on the cycle after `rst` drops.

Source files
------------

// File: rtl/ama_riscv_lsu_ctrl.sv
// ama_riscv_lsu_ctrl: load/store sequencer between the memory stage and a word-addressed DMEM.
// Misaligned accesses become two word accesses; load words are merged, shifted and extended.
module ama_riscv_lsu_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_width_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        dmem_en_o,
    output logic [3:0]  dmem_we_o,
    output logic [29:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i
);
    typedef enum logic {IDLE, SPLIT} state_t;

    state_t      state_q;
    logic [29:0] wa_q;
    logic [31:0] wdata_q;
    logic [31:0] low_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        err_q;
    logic        split_q;
    logic        we_q;
    logic        resp_q;

    logic        in_split;
    logic        accept;
    logic        bad;
    logic        split_req;
    logic [1:0]  s_off;
    logic [1:0]  s_size;
    logic [31:0] s_wdata;
    logic        s_we;
    logic [3:0]  mask;
    logic [7:0]  mask_sh;
    logic [63:0] wdata_sh;
    logic [63:0] merged;
    logic [31:0] sel;
    logic [31:0] ext;

    always_comb begin
        in_split    = state_q == SPLIT;
        req_ready_o = !rst_i && !in_split;
        accept      = req_valid_i && req_ready_o;
        bad         = req_width_i[1:0] == 2'd3 || req_width_i == 3'b110;
        split_req   = !bad && ((req_width_i[1:0] == 2'd1 && req_addr_i[1:0] == 2'd3) ||
                               (req_width_i[1:0] == 2'd2 && req_addr_i[1:0] != 2'd0));
        // The SPLIT cycle replays the registered request; the lane math is shared.
        s_off       = in_split ? off_q : req_addr_i[1:0];
        s_size      = in_split ? size_q : req_width_i[1:0];
        s_wdata     = in_split ? wdata_q : req_wdata_i;
        s_we        = in_split ? we_q : req_we_i;
        mask        = s_size == 2'd0 ? 4'b0001 : s_size == 2'd1 ? 4'b0011 : 4'b1111;
        mask_sh     = {4'b0000, mask} << s_off;
        wdata_sh    = {32'h0, s_wdata} << {s_off, 3'b000};
        dmem_en_o   = (accept && !bad) || (in_split && !rst_i);
        dmem_addr_o = in_split ? wa_q + 30'd1 : req_addr_i[31:2];
        dmem_we_o   = !dmem_en_o || !s_we ? 4'b0000 : in_split ? mask_sh[7:4] : mask_sh[3:0];
        dmem_wdata_o = !dmem_en_o ? 32'h0 : in_split ? wdata_sh[63:32] : wdata_sh[31:0];
        merged      = {split_q ? dmem_rdata_i : 32'h0, split_q ? low_q : dmem_rdata_i};
        sel         = 32'(merged >> {off_q, 3'b000});
        ext         = size_q == 2'd0 ? {{24{sel[7] & ~uns_q}}, sel[7:0]} :
                      size_q == 2'd1 ? {{16{sel[15] & ~uns_q}}, sel[15:0]} : sel;
        resp_valid_o = resp_q && !rst_i;
        resp_err_o  = resp_valid_o && err_q;
        resp_rdata_o = resp_valid_o && !err_q ? ext : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            resp_q  <= 1'b0;
            low_q   <= 32'h0;
            wa_q    <= 30'h0;
            wdata_q <= 32'h0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            we_q    <= 1'b0;
        end else if (in_split) begin
            state_q <= IDLE;
            resp_q  <= !we_q;
            low_q   <= dmem_rdata_i;
        end else begin
            resp_q <= accept && !req_we_i && !split_req;
            if (accept) begin
                state_q <= split_req ? SPLIT : IDLE;
                wa_q    <= req_addr_i[31:2];
                wdata_q <= req_wdata_i;
                off_q   <= req_addr_i[1:0];
                size_q  <= req_width_i[1:0];
                uns_q   <= req_width_i[2];
                err_q   <= bad;
                split_q <= split_req;
                we_q    <= req_we_i;
            end
        end
    end
endmodule

// File: tb/tb_ama_riscv_lsu_ctrl.sv
// tb_ama_riscv_lsu_ctrl: byte-level reference model with a per-cycle expectation schedule,
// a 16-word synchronous DMEM, directed literal checks and randomized traffic.
module tb_ama_riscv_lsu_ctrl;
    localparam int N = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_width = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [29:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          chk_on = 1'b0;
    logic [31:0] mem [16];
    logic [7:0]  ref_mem [64];
    bit          load_mem = 1'b0;
    int          load_idx = 0;
    logic [31:0] load_word = 32'h0;

    bit          e_rdy [N];
    bit          e_en [N];
    bit          e_rv [N];
    bit          e_err [N];
    logic [31:0] e_rd [N];
    logic [29:0] e_addr [N];

    always #5 clk = ~clk;

    ama_riscv_lsu_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_width_i(req_width), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .dmem_en_o(dmem_en), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_mem) mem[load_idx] <= load_word;
        if (dmem_en) begin
            dmem_rdata <= mem[dmem_addr[3:0]];
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) mem[dmem_addr[3:0]][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", 32'(req_ready), 32'(e_rdy[cyc]));
            chk("dmem_en", 32'(dmem_en), 32'(e_en[cyc]));
            if (e_en[cyc]) chk("dmem_addr", 32'(dmem_addr), 32'(e_addr[cyc]));
            else chk("dmem_we_idle", 32'(dmem_we), 32'h0);
            chk("resp_valid", 32'(resp_valid), 32'(e_rv[cyc]));
            chk("resp_rdata", resp_rdata, e_rv[cyc] ? e_rd[cyc] : 32'h0);
            if (e_rv[cyc]) chk("resp_err", 32'(resp_err), 32'(e_err[cyc]));
        end
    end

    task automatic clear(int k);
        e_rdy[k] = 1'b1;
        e_en[k] = 1'b0;
        e_rv[k] = 1'b0;
        e_err[k] = 1'b0;
        e_rd[k] = 32'h0;
        e_addr[k] = 30'h0;
    endtask

    // Reference: byte-addressed memory (64 bytes, aliased like the DMEM) and cycle schedule.
    task automatic model(int c, bit we, logic [31:0] a, logic [2:0] w, logic [31:0] d);
        int          n = 1 << w[1:0];
        bit          bad = (w[1:0] == 2'd3) || (w == 3'b110);
        bit          spl = !bad && (int'(a[1:0]) + n > 4);
        int          rc = spl ? c + 2 : c + 1;
        logic [31:0] v = 32'h0;
        if (bad) begin
            if (!we) begin
                e_rv[c+1] = 1'b1;
                e_err[c+1] = 1'b1;
                e_rd[c+1] = 32'h0;
            end
            return;
        end
        e_en[c] = 1'b1;
        e_addr[c] = a[31:2];
        if (spl) begin
            e_en[c+1] = 1'b1;
            e_addr[c+1] = a[31:2] + 30'd1;
            e_rdy[c+1] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            int k = (int'(a[5:0]) + i) % 64;
            if (we) ref_mem[k] = d[8*i +: 8];
            else v[8*i +: 8] = ref_mem[k];
        end
        if (!we) begin
            if (n < 4 && !w[2] && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
            e_rv[rc] = 1'b1;
            e_err[rc] = 1'b0;
            e_rd[rc] = v;
        end
    endtask

    task automatic step(bit v, bit we, logic [31:0] a, logic [2:0] w, logic [31:0] d);
        @(posedge clk);
        #1;
        req_valid = v;
        req_we = we;
        req_addr = a;
        req_width = w;
        req_wdata = d;
        if (v && e_rdy[cyc]) model(cyc, we, a, w, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    endtask

    task automatic set_word(int i, logic [31:0] w);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        load_idx = i;
        load_word = w;
        load_mem = 1'b1;
        for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
        @(posedge clk);
        #1;
        load_mem = 1'b0;
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            req_valid = 1'b0;
            chk_on = 1'b1;
            for (int k = cyc; k < cyc + 4; k++) clear(k);
            e_rdy[cyc] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] widths [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] bads [3] = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < N; i++) clear(i);
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        do_reset(2);
        set_word(0, 32'h44332211);
        set_word(1, 32'h88776655);

        step(1, 0, 32'h1, 3'b000, 0); idle(); @(negedge clk); chk("lb_1", resp_rdata, 32'h00000022);
        step(1, 0, 32'h7, 3'b100, 0); idle(); @(negedge clk); chk("lbu_7", resp_rdata, 32'h00000088);
        step(1, 0, 32'h7, 3'b000, 0); idle(); @(negedge clk); chk("lb_7", resp_rdata, 32'hFFFFFF88);

        step(1, 0, 32'h3, 3'b001, 0); @(negedge clk); chk("lh3_addr0", 32'(dmem_addr), 32'h0);
        idle(); @(negedge clk);
        chk("lh3_ready", 32'(req_ready), 32'h0);
        chk("lh3_addr1", 32'(dmem_addr), 32'h1);
        idle(); @(negedge clk); chk("lh_3", resp_rdata, 32'h00005544);
        step(1, 0, 32'h2, 3'b010, 0); idle(); idle(); @(negedge clk); chk("lw_2", resp_rdata, 32'h66554433);

        step(1, 0, 32'h0, 3'b010, 0);
        step(1, 0, 32'h4, 3'b010, 0); @(negedge clk); chk("b2b_0", resp_rdata, 32'h44332211);
        step(1, 0, 32'h0, 3'b010, 0); @(negedge clk); chk("b2b_1", resp_rdata, 32'h88776655);
        idle(); @(negedge clk); chk("b2b_2", resp_rdata, 32'h44332211);
        idle();

        step(1, 1, 32'h3, 3'b010, 32'hAABBCCDD); @(negedge clk);
        chk("sw_addr0", 32'(dmem_addr), 32'h0);
        chk("sw_we0", 32'(dmem_we), 32'b1000);
        chk("sw_data0", 32'(dmem_wdata[31:24]), 32'hDD);
        idle(); @(negedge clk);
        chk("sw_addr1", 32'(dmem_addr), 32'h1);
        chk("sw_we1", 32'(dmem_we), 32'b0111);
        chk("sw_data1", 32'(dmem_wdata[23:0]), 32'hAABBCC);
        idle();

        step(1, 0, 32'hFFFFFFFE, 3'b010, 0); @(negedge clk); chk("wrap_addr0", 32'(dmem_addr), 32'h3FFFFFFF);
        idle(); @(negedge clk); chk("wrap_addr1", 32'(dmem_addr), 32'h0);
        idle();

        step(1, 0, 32'h0, 3'b011, 0); @(negedge clk); chk("bad_no_en", 32'(dmem_en), 32'h0);
        idle(); @(negedge clk);
        chk("bad_valid", 32'(resp_valid), 32'h1);
        chk("bad_err", 32'(resp_err), 32'h1);
        chk("bad_rdata", resp_rdata, 32'h0);
        idle();

        step(1, 0, 32'h1, 3'b010, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        for (int k = cyc; k < cyc + 4; k++) clear(k);
        e_rdy[cyc] = 1'b0;
        @(negedge clk);
        chk("rst_no_2nd", 32'(dmem_en), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_resp", 32'(resp_valid), 32'h0);
        chk("rst_ready_after", 32'(req_ready), 32'h1);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFC0 | 32'($urandom_range(0, 63)))
                                                          : 32'($urandom_range(0, 63));
            logic [2:0]  w = ($urandom_range(0, 9) < 9) ? widths[$urandom_range(0, 4)] : bads[$urandom_range(0, 2)];
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, w, $urandom);
        end
        repeat (4) idle();
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            chk("mem_word", mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
